// File: rtl/mem_port_sched.sv
// mem_port_sched: shares one single-port memory between PORTS_NUM requesters.
// A round-robin arbiter with a rotating priority pointer grants one port for a
// burst; the granted port's address, write data and write enable are muxed onto
// the memory port, and read-return valids are steered back after RD_LAT cycles.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req/last/we         per-port request, end-of-burst qualifier, write enable
//   addr/wdata          per-port packed address / write data (port i at [i*W +: W])
//   gnt                 registered one-hot grant (or 0)
//   ack                 per-port access accepted this cycle
//   rvalid/rdata        per-port read-return valid, shared read data bus
//   mem_*               memory-side strobe, write enable, address, data in/out
module mem_port_sched #(
  parameter int unsigned PORTS_NUM = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PORTS_NUM-1:0]        req,
  input  logic [PORTS_NUM-1:0]        last,
  input  logic [PORTS_NUM-1:0]        we,
  input  logic [PORTS_NUM*ADDR_W-1:0] addr,
  input  logic [PORTS_NUM*DATA_W-1:0] wdata,
  output logic [PORTS_NUM-1:0]        gnt,
  output logic [PORTS_NUM-1:0]        ack,
  output logic [PORTS_NUM-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned IdxW = $clog2(PORTS_NUM);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {StIdle, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [PORTS_NUM-1:0]   gnt_q, gnt_d;
  idx_t                   ptr_q, ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [RD_LAT-1:0]      pv_q;
  idx_t                   pi_q [RD_LAT];

  idx_t                   g;
  idx_t                   win;
  logic                   access;
  logic                   rd;
  int unsigned            j;

  // Grant is one-hot (or zero), so a plain priority encode recovers its index.
  always_comb begin
    g = '0;
    for (int unsigned i = 0; i < PORTS_NUM; i++) begin
      if (gnt_q[i]) g = idx_t'(i);
    end
  end

  // Rotating-priority scan starting just after the last winner.
  always_comb begin
    logic found;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int unsigned k = 1; k <= PORTS_NUM; k++) begin
      j = (32'(ptr_q) + k) % PORTS_NUM;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = idx_t'(j);
      end
    end
  end

  // gnt_q is zero outside BUSY, so this alone qualifies an access.
  assign access = |(gnt_q & req);
  assign rd     = access & ~we[g];
  assign gnt    = gnt_q;
  assign ack    = gnt_q & req;
  assign rdata  = mem_rdata;

  always_comb begin
    mem_en    = access;
    mem_we    = access & we[g];
    mem_addr  = '0;
    mem_wdata = '0;
    if (access) begin
      mem_addr  = addr[g*ADDR_W +: ADDR_W];
      mem_wdata = wdata[g*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          cnt_d      = '0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (access) cnt_d = cnt_q + 1'b1;
        if (!access || last[g] || cnt_q == CntW'(MAX_BURST - 1)) begin
          gnt_d   = '0;
          ptr_d   = g;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= idx_t'(PORTS_NUM - 1);
      cnt_q   <= '0;
      pv_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pv_q[0] <= rd;
      for (int unsigned i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
    end
  end

  // Port indices ride alongside the valid bits; they only matter when valid.
  always_ff @(posedge clk) begin
    pi_q[0] <= g;
    for (int unsigned i = 1; i < RD_LAT; i++) pi_q[i] <= pi_q[i-1];
  end

  always_comb begin
    rvalid = '0;
    if (pv_q[RD_LAT-1]) rvalid[pi_q[RD_LAT-1]] = 1'b1;
  end

endmodule
